// File: rtl/thunder_tsip_parser.sv
// TSIP byte-stream decoder: removes DLE stuffing and captures the Primary Timing
// packet (0x8F/0xAB), presenting its UTC fields with a one-cycle valid strobe.
module thunder_tsip_parser #(
  parameter logic [7:0]  c_PKT_ID      = 8'h8F,
  parameter logic [7:0]  c_SUBCODE     = 8'hAB,
  parameter int unsigned c_PAYLOAD_LEN = 17
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_byte,
  input  logic        i_rx_dv,
  output logic        o_thunder_packet_dv,
  output logic [15:0] o_thunder_year,
  output logic [7:0]  o_thunder_month,
  output logic [7:0]  o_thunder_day,
  output logic [7:0]  o_thunder_hour,
  output logic [7:0]  o_thunder_minutes,
  output logic [7:0]  o_thunder_seconds,
  output logic [15:0] o_utc_offset,
  output logic [7:0]  o_timing_flag,
  output logic        o_frame_err
);

  localparam logic [7:0]     DLE     = 8'h10;
  localparam logic [7:0]     ETX     = 8'h03;
  localparam int unsigned    CW      = 5;
  localparam logic [CW-1:0]  LEN     = CW'(c_PAYLOAD_LEN);
  localparam logic [CW-1:0]  CNT_MAX = CW'(c_PAYLOAD_LEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_BODY, S_BODY_DLE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic            capture_q, capture_d;
  logic [7:0]      shadow_q [c_PAYLOAD_LEN];

  logic            id_c;
  logic            data_c;
  logic [7:0]      data_byte_c;
  logic            eof_c;
  logic            wr_en_c;
  logic            commit_c;
  logic            err_c;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      capture_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      capture_q <= capture_d;
    end
  end

  // Frame decoding: classify the accepted byte as ID, data, end-of-frame or abort.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    capture_d   = capture_q;
    id_c        = 1'b0;
    data_c      = 1'b0;
    data_byte_c = i_rx_byte;
    eof_c       = 1'b0;
    err_c       = 1'b0;

    if (i_rx_dv) begin
      unique case (state_q)
        S_IDLE: begin
          if (i_rx_byte == DLE) state_d = S_START;
        end
        S_START: begin
          if (i_rx_byte == DLE || i_rx_byte == ETX) state_d = S_IDLE;
          else                                      id_c    = 1'b1;
        end
        S_BODY: begin
          if (i_rx_byte == DLE) state_d = S_BODY_DLE;
          else                  data_c  = 1'b1;
        end
        S_BODY_DLE: begin
          if (i_rx_byte == DLE) begin
            data_c      = 1'b1;
            data_byte_c = DLE;
            state_d     = S_BODY;
          end else if (i_rx_byte == ETX) begin
            eof_c   = 1'b1;
            state_d = S_IDLE;
          end else begin
            // Unstuffed DLE + byte: resync, treating the byte as a fresh ID.
            id_c  = 1'b1;
            err_c = capture_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (id_c) begin
      state_d   = S_BODY;
      count_d   = '0;
      capture_d = (i_rx_byte == c_PKT_ID);
    end

    if (data_c && (count_q < CNT_MAX)) count_d = count_q + CW'(1);

    wr_en_c  = data_c && capture_q && (count_q < LEN);
    commit_c = eof_c && capture_q && (count_q == LEN) && (shadow_q[0] == c_SUBCODE);
    if (eof_c && capture_q && !commit_c) err_c = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < int'(c_PAYLOAD_LEN); i++) shadow_q[i] <= '0;
    end else if (wr_en_c) begin
      shadow_q[count_q] <= data_byte_c;
    end
  end

  // Output fields load together on commit; strobes last one cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_thunder_packet_dv <= 1'b0;
      o_frame_err         <= 1'b0;
      o_thunder_year      <= '0;
      o_thunder_month     <= '0;
      o_thunder_day       <= '0;
      o_thunder_hour      <= '0;
      o_thunder_minutes   <= '0;
      o_thunder_seconds   <= '0;
      o_utc_offset        <= '0;
      o_timing_flag       <= '0;
    end else begin
      o_thunder_packet_dv <= commit_c;
      o_frame_err         <= err_c;
      if (commit_c) begin
        o_utc_offset      <= {shadow_q[7], shadow_q[8]};
        o_timing_flag     <= shadow_q[9];
        o_thunder_seconds <= shadow_q[10];
        o_thunder_minutes <= shadow_q[11];
        o_thunder_hour    <= shadow_q[12];
        o_thunder_day     <= shadow_q[13];
        o_thunder_month   <= shadow_q[14];
        o_thunder_year    <= {shadow_q[15], shadow_q[16]};
      end
    end
  end

endmodule
